// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared next-PC encodings, reset PC and fetch FSM states
package fetch_pkg;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam int          FETCH_IM_AW    = 10;

  typedef enum logic {
    RUN,
    PEND
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational redirect decision and target from D-stage branch/jump info
module npc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  npc_op,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic        d_cmp_true,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] w_br_tgt;

  assign w_br_tgt = d_pc + 32'd4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};

  always_comb begin
    redirect = 1'b0;
    target   = w_br_tgt;
    case (npc_op)
      NPC_BR: redirect = d_cmp_true;
      NPC_J: begin
        redirect = 1'b1;
        target   = {d_pc[31:28], d_imm26, 2'b00};
      end
      NPC_JR: begin
        redirect = 1'b1;
        target   = d_rs_val;
      end
      default: redirect = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC, F/D register and stall-tolerant redirect FSM
// Optional FETCH_ADEL_CHECK_EN adds fd_exc and replaces misaligned/out-of-ROM fetches by a nop.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
`ifdef FETCH_ADEL_CHECK_EN
  , parameter int IM_AW = FETCH_IM_AW
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic        d_cmp_true,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc8,
`ifdef FETCH_ADEL_CHECK_EN
  output logic        fd_exc,
`endif
  output logic        fd_valid
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_pend_tgt, w_pend_nxt;
  logic [31:0]  r_fd_instr, r_fd_pc;
  logic         r_fd_valid;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_fd_word;

  npc_calc u_npc_calc (
    .npc_op     (npc_op),
    .d_pc       (d_pc),
    .d_imm26    (d_imm26),
    .d_rs_val   (d_rs_val),
    .d_cmp_true (d_cmp_true),
    .redirect   (w_redirect),
    .target     (w_target)
  );

  // A live redirect always wins over a held one; a stall only parks the newest target.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_tgt;
    if (stall) begin
      if (w_redirect) begin
        w_pend_nxt  = w_target;
        w_state_nxt = PEND;
      end
    end else if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_state_nxt = RUN;
    end else if (r_state == PEND) begin
      w_pc_nxt    = r_pend_tgt;
      w_state_nxt = RUN;
    end else begin
      w_pc_nxt = r_pc + 32'd4;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  localparam logic [32:0] ROM_END = {1'b0, RESET_PC} + (33'd4 << IM_AW);

  logic w_adel;
  logic r_fd_exc;

  assign w_adel    = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || ({1'b0, r_pc} >= ROM_END);
  assign w_fd_word = w_adel ? 32'd0 : im_instr;
  assign fd_exc    = r_fd_exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fd_exc <= 1'b0;
    end else if (!stall) begin
      r_fd_exc <= w_adel;
    end
  end
`else
  assign w_fd_word = im_instr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_pend_tgt <= 32'd0;
      r_fd_instr <= 32'd0;
      r_fd_pc    <= 32'd0;
      r_fd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_nxt;
      if (!stall) begin
        r_fd_instr <= w_fd_word;
        r_fd_pc    <= r_pc;
        r_fd_valid <= 1'b1;
      end
    end
  end

  assign im_addr  = r_pc;
  assign fd_instr = r_fd_instr;
  assign fd_pc    = r_fd_pc;
  assign fd_pc8   = r_fd_pc + 32'd8;
  assign fd_valid = r_fd_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard bench for fetch_ctrl (FETCH_ADEL_CHECK_EN aware)
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_op = NPC_PC4;
  logic [31:0] d_pc = 32'd0;
  logic [25:0] d_imm26 = 26'd0;
  logic [31:0] d_rs_val = 32'd0;
  logic        d_cmp_true = 1'b0;
  logic [31:0] im_addr, im_instr, fd_instr, fd_pc, fd_pc8;
  logic        fd_valid;
  logic        fd_exc_obs;

  always #5 clk = ~clk;

  // ROM stand-in: each word is the bitwise complement of its address
  assign im_instr = ~im_addr;

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_op     (npc_op),
    .d_pc       (d_pc),
    .d_imm26    (d_imm26),
    .d_rs_val   (d_rs_val),
    .d_cmp_true (d_cmp_true),
    .im_addr    (im_addr),
    .im_instr   (im_instr),
    .fd_instr   (fd_instr),
    .fd_pc      (fd_pc),
    .fd_pc8     (fd_pc8),
`ifdef FETCH_ADEL_CHECK_EN
    .fd_exc     (fd_exc_obs),
`endif
    .fd_valid   (fd_valid)
  );

`ifndef FETCH_ADEL_CHECK_EN
  assign fd_exc_obs = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] fd_pc;
    logic [31:0] fd_instr;
    logic        fd_valid;
    logic        fd_exc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_fd_pc;
  logic        m_valid;

  function automatic logic exp_exc(input logic [31:0] a, input logic v);
`ifdef FETCH_ADEL_CHECK_EN
    return v && ((a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_4000));
`else
    return 1'b0 && v && (a != 32'd0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] fpc, input logic v);
    exp_t e;
    e.pc       = pc;
    e.fd_pc    = fpc;
    e.fd_valid = v;
    e.fd_exc   = exp_exc(fpc, v);
    e.fd_instr = (v && !e.fd_exc) ? ~fpc : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".im_addr"},  im_addr,  e.pc);
      check({tag, ".fd_pc"},    fd_pc,    e.fd_pc);
      check({tag, ".fd_pc8"},   fd_pc8,   e.fd_pc + 32'd8);
      check({tag, ".fd_instr"}, fd_instr, e.fd_instr);
      check({tag, ".fd_valid"}, {31'd0, fd_valid},   {31'd0, e.fd_valid});
      check({tag, ".fd_exc"},   {31'd0, fd_exc_obs}, {31'd0, e.fd_exc});
    end
  endtask

  // Reset with a live JR on the inputs; stall level is a parameter to show it is ignored.
  task automatic do_reset(input logic st, input string tag);
    reset    = 1'b1;
    stall    = st;
    npc_op   = NPC_JR;
    d_rs_val = 32'h0000_5000;
    push_exp(32'h0000_3000, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    compare_out(tag);
    reset   = 1'b0;
    stall   = 1'b0;
    npc_op  = NPC_PC4;
    m_pc    = 32'h0000_3000;
    m_fd_pc = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic step(input logic st, input logic [1:0] op, input logic [31:0] dpc,
                      input logic [25:0] imm, input logic [31:0] rs, input logic cmp,
                      input logic [31:0] exp_pc, input string tag);
    stall      = st;
    npc_op     = op;
    d_pc       = dpc;
    d_imm26    = imm;
    d_rs_val   = rs;
    d_cmp_true = cmp;
    if (!st) begin
      m_fd_pc = m_pc;
      m_valid = 1'b1;
    end
    push_exp(exp_pc, m_fd_pc, m_valid);
    @(posedge clk);
    #1;
    compare_out(tag);
    m_pc = exp_pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1'b0, "reset0");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3004, "run1");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3008, "run2");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_300C, "run3");

    do_reset(1'b1, "reset_stall_hi");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3004, "pre_br1");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3008, "pre_br2");
    step(1'b0, NPC_BR, 32'h0000_3004, 26'h000_FFFF, 32'd0, 1'b1, 32'h0000_3004, "br_taken");

    do_reset(1'b0, "reset1");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3004, "pre_nt1");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3008, "pre_nt2");
    step(1'b0, NPC_BR, 32'h0000_3004, 26'h000_FFFF, 32'd0, 1'b0, 32'h0000_300C, "br_not_taken");
    step(1'b0, NPC_J, 32'h0000_3000, 26'h000_0C10, 32'd0, 1'b0, 32'h0000_3040, "jump");

    step(1'b1, NPC_JR,  32'd0, 26'd0, 32'h0000_3100, 1'b0, 32'h0000_3040, "jr_stall1");
    step(1'b1, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3040, "jr_stall2");
    step(1'b1, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3040, "jr_stall3");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3100, "jr_release");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3104, "jr_after");

    step(1'b1, NPC_JR,  32'd0, 26'd0, 32'h0000_3100, 1'b0, 32'h0000_3104, "pend_set");
    step(1'b1, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3104, "pend_hold");
    step(1'b0, NPC_JR,  32'd0, 26'd0, 32'h0000_3200, 1'b0, 32'h0000_3200, "live_beats_pend");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3204, "pend_cleared");

    step(1'b1, NPC_JR, 32'd0, 26'd0, 32'h0000_3300, 1'b0, 32'h0000_3204, "pend_before_reset");
    do_reset(1'b0, "reset_in_pend");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3004, "pend_lost1");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3008, "pend_lost2");

    step(1'b0, NPC_JR,  32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, "wrap_jr");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_0000, "wrap0");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_0004, "wrap1");

    step(1'b0, NPC_JR,  32'd0, 26'd0, 32'h0000_3002, 1'b0, 32'h0000_3002, "adel_jr");
    step(1'b0, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3006, "adel_fetch");
    step(1'b1, NPC_PC4, 32'd0, 26'd0, 32'd0, 1'b0, 32'h0000_3006, "adel_hold");

    total++;
    assert (sb_q.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
